// File: rtl/b06_eql_gen_pkg.sv
// Shared types and defaults for the b06 equality/continuity generator.
package b06_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_HIT   = 2'b10
  } state_e;

  localparam int unsigned W_DEF      = 8;
  localparam int unsigned THRESH_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 4;

  // Threshold must be reachable without the run counter wrapping.
  function automatic bit thresh_ok(input int unsigned thresh, input int unsigned cnt_w);
    return (thresh >= 1) && (cnt_w >= 1) && (cnt_w < 32) && (thresh < (32'd1 << cnt_w));
  endfunction

endpackage

// File: rtl/b06_eql_gen_if.sv
// Sample/reference/handshake bundle between the b06 controller side and the generator.
interface b06_eql_gen_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 4
);
  logic [W-1:0]     DATA_IN;
  logic             DATA_VALID;
  logic [W-1:0]     REF_IN;
  logic             REF_LOAD;
  logic             ENABLE_COUNT;
  logic             ACKOUT;
  logic             EQL;
  logic             CONT_EQL;
  logic [CNT_W-1:0] RUN_CNT;

  modport master (
    output DATA_IN, DATA_VALID, REF_IN, REF_LOAD, ENABLE_COUNT, ACKOUT,
    input  EQL, CONT_EQL, RUN_CNT
  );

  modport slave (
    input  DATA_IN, DATA_VALID, REF_IN, REF_LOAD, ENABLE_COUNT, ACKOUT,
    output EQL, CONT_EQL, RUN_CNT
  );
endinterface

// File: rtl/b06_eql_gen_run_counter.sv
// Saturating consecutive-match counter; clear wins over increment.
module b06_run_counter #(
  parameter int unsigned THRESH = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_thresh
);

  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_TOP)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Set when one more match completes the run; decoded from the register only.
  assign o_at_thresh = (r_cnt == CNT_LAST);
  assign o_cnt       = r_cnt;

endmodule

// File: rtl/b06_eql_gen.sv
// Equality / continuity generator feeding EQL and CONT_EQL of the b06 controller.
module b06_eql_gen
  import b06_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned THRESH = THRESH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic         clock,
  input  logic         RESET_G,
  b06_eql_gen_if.slave bus
);

  if (!thresh_ok(THRESH, CNT_W)) begin : g_bad_thresh
    $error("b06_eql_gen: THRESH must satisfy 1 <= THRESH < 2**CNT_W");
  end

  state_e           r_state;
  state_e           w_state_d;
  logic [W-1:0]     r_ref;
  logic             r_eql;
  logic             r_cont_eql;
  logic             w_match;
  logic             w_clr;
  logic             w_inc;
  logic             w_at_thresh;
  logic [CNT_W-1:0] w_cnt;

  // Compare against the reference held before any same-cycle load.
  assign w_match = bus.DATA_VALID && (bus.DATA_IN == r_ref);

  always_comb begin
    w_state_d = r_state;
    w_clr     = 1'b0;
    w_inc     = 1'b0;
    if (bus.ACKOUT) begin
      w_state_d = S_IDLE;
      w_clr     = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_clr = 1'b1;
          if (bus.ENABLE_COUNT) w_state_d = S_COUNT;
        end
        S_COUNT: begin
          if (bus.REF_LOAD) begin
            w_clr = 1'b1;
          end else if (!bus.ENABLE_COUNT) begin
            w_state_d = S_IDLE;
            w_clr     = 1'b1;
          end else if (w_match) begin
            w_inc = 1'b1;
            if (w_at_thresh) w_state_d = S_HIT;
          end else if (bus.DATA_VALID) begin
            w_clr = 1'b1;
          end
        end
        S_HIT: ;
        default: begin
          w_state_d = S_IDLE;
          w_clr     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (RESET_G) begin
      r_state    <= S_IDLE;
      r_cont_eql <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cont_eql <= (w_state_d == S_HIT);
    end
  end

  // Reference register and EQL; a sample alongside a load is dropped.
  always_ff @(posedge clock) begin
    if (RESET_G) begin
      r_ref <= '0;
      r_eql <= 1'b0;
    end else if (bus.REF_LOAD) begin
      r_ref <= bus.REF_IN;
      r_eql <= 1'b0;
    end else if (bus.DATA_VALID) begin
      r_eql <= w_match;
    end
  end

  b06_run_counter #(
    .THRESH (THRESH),
    .CNT_W  (CNT_W)
  ) u_run_counter (
    .clk         (clock),
    .rst         (RESET_G),
    .i_clr       (w_clr),
    .i_inc       (w_inc),
    .o_cnt       (w_cnt),
    .o_at_thresh (w_at_thresh)
  );

  assign bus.EQL      = r_eql;
  assign bus.CONT_EQL = r_cont_eql;
  assign bus.RUN_CNT  = w_cnt;

endmodule

// File: tb/tb_b06_eql_gen.sv
// Vector-table bench for b06_eql_gen at THRESH=4 and THRESH=1.
module tb_b06_eql_gen;

  typedef struct {
    bit         rst;
    bit         dv;
    logic [7:0] din;
    bit         rl;
    logic [7:0] rin;
    bit         en;
    bit         ack;
    bit         eql;
    bit         cont;
    logic [3:0] cnt;
  } vec_t;

  logic clock = 1'b0;
  logic rst4  = 1'b1;
  logic rst1  = 1'b1;

  int checks = 0;
  int errors = 0;

  vec_t vecs4[$];
  vec_t vecs1[$];
  vec_t sb[$];

  always #5 clock = ~clock;

  b06_eql_gen_if #(.W(8), .CNT_W(4)) if4 ();
  b06_eql_gen_if #(.W(8), .CNT_W(4)) if1 ();

  b06_eql_gen #(.W(8), .THRESH(4), .CNT_W(4)) u_dut4 (
    .clock   (clock),
    .RESET_G (rst4),
    .bus     (if4.slave)
  );

  b06_eql_gen #(.W(8), .THRESH(1), .CNT_W(4)) u_dut1 (
    .clock   (clock),
    .RESET_G (rst1),
    .bus     (if1.slave)
  );

  function automatic vec_t v(bit rst, bit dv, logic [7:0] din, bit rl, logic [7:0] rin,
                             bit en, bit ack, bit eql, bit cont, logic [3:0] cnt);
    vec_t r;
    r.rst = rst; r.dv = dv; r.din = din; r.rl = rl; r.rin = rin;
    r.en = en; r.ack = ack; r.eql = eql; r.cont = cont; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  // Drive one vector, queue its expectation, compare just after the capturing edge.
  task automatic apply(input vec_t vi, input bit one, input int idx);
    vec_t e;
    bit   g_eql;
    bit   g_cont;
    logic [3:0] g_cnt;
    if (one) begin
      rst1 = vi.rst; if1.DATA_VALID = vi.dv; if1.DATA_IN = vi.din; if1.REF_LOAD = vi.rl;
      if1.REF_IN = vi.rin; if1.ENABLE_COUNT = vi.en; if1.ACKOUT = vi.ack;
    end else begin
      rst4 = vi.rst; if4.DATA_VALID = vi.dv; if4.DATA_IN = vi.din; if4.REF_LOAD = vi.rl;
      if4.REF_IN = vi.rin; if4.ENABLE_COUNT = vi.en; if4.ACKOUT = vi.ack;
    end
    sb.push_back(vi);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard vec %0d: got empty expected entry", idx);
    end else begin
      e = sb.pop_front();
      g_eql  = one ? if1.EQL      : if4.EQL;
      g_cont = one ? if1.CONT_EQL : if4.CONT_EQL;
      g_cnt  = one ? if1.RUN_CNT  : if4.RUN_CNT;
      check(one ? "t1_eql"  : "eql",  idx, int'(g_eql),  int'(e.eql));
      check(one ? "t1_cont" : "cont", idx, int'(g_cont), int'(e.cont));
      check(one ? "t1_cnt"  : "cnt",  idx, int'(g_cnt),  int'(e.cnt));
    end
    @(negedge clock);
  endtask

  initial begin
    {if4.DATA_VALID, if4.REF_LOAD, if4.ENABLE_COUNT, if4.ACKOUT} = 4'b0;
    {if1.DATA_VALID, if1.REF_LOAD, if1.ENABLE_COUNT, if1.ACKOUT} = 4'b0;
    if4.DATA_IN = 8'h00; if4.REF_IN = 8'h00;
    if1.DATA_IN = 8'h00; if1.REF_IN = 8'h00;

    //                      rst dv din   rl rin   en ack  eql cont cnt
    // reset held with a valid sample, then ref=0 matches 0x00
    vecs4.push_back(v(1, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs4.push_back(v(1, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs4.push_back(v(0, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0));
    // load 0x5A, enable (sample in IDLE not counted), four matches to hit
    vecs4.push_back(v(0, 0, 8'h00, 1, 8'h5A, 0, 0, 0, 0, 0));
    vecs4.push_back(v(0, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 0, 0));
    vecs4.push_back(v(0, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 0, 1));
    vecs4.push_back(v(0, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 0, 2));
    vecs4.push_back(v(0, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 0, 3));
    vecs4.push_back(v(0, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 1, 4));
    for (int i = 0; i < 10; i++) vecs4.push_back(v(0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 1, 4));
    // in HIT: enable dropped and a mismatch are ignored by the FSM
    vecs4.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 4));
    vecs4.push_back(v(0, 1, 8'h3C, 0, 8'h00, 0, 0, 0, 1, 4));
    // acknowledge, then re-enable and count restarts
    vecs4.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0));
    vecs4.push_back(v(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0));
    vecs4.push_back(v(0, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 0, 1));
    // break in run
    vecs4.push_back(v(0, 1, 8'h3C, 0, 8'h00, 1, 0, 0, 0, 0));
    vecs4.push_back(v(0, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 0, 1));
    vecs4.push_back(v(0, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 0, 2));
    vecs4.push_back(v(0, 1, 8'h3C, 0, 8'h00, 1, 0, 0, 0, 0));
    vecs4.push_back(v(0, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 0, 1));
    // load collision at RUN_CNT=2: sample dropped
    vecs4.push_back(v(0, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 0, 2));
    vecs4.push_back(v(0, 1, 8'h5A, 1, 8'h11, 1, 0, 0, 0, 0));
    vecs4.push_back(v(0, 1, 8'h11, 0, 8'h00, 1, 0, 1, 0, 1));
    vecs4.push_back(v(0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 1));
    vecs4.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0));
    // ACKOUT + REF_LOAD with the THRESH-th match: ACKOUT wins
    vecs4.push_back(v(0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0));
    vecs4.push_back(v(0, 1, 8'h11, 0, 8'h00, 1, 0, 1, 0, 1));
    vecs4.push_back(v(0, 1, 8'h11, 0, 8'h00, 1, 0, 1, 0, 2));
    vecs4.push_back(v(0, 1, 8'h11, 0, 8'h00, 1, 0, 1, 0, 3));
    vecs4.push_back(v(0, 1, 8'h11, 1, 8'h22, 1, 1, 0, 0, 0));
    vecs4.push_back(v(0, 1, 8'h22, 0, 8'h00, 1, 0, 1, 0, 0));
    // reset mid-run clears the reference too
    vecs4.push_back(v(0, 1, 8'h22, 0, 8'h00, 1, 0, 1, 0, 1));
    vecs4.push_back(v(1, 1, 8'h22, 0, 8'h00, 1, 0, 0, 0, 0));
    vecs4.push_back(v(0, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0));
    // REF_LOAD in HIT loads the reference but keeps the counter
    vecs4.push_back(v(0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0));
    vecs4.push_back(v(0, 1, 8'h00, 0, 8'h00, 1, 0, 1, 0, 1));
    vecs4.push_back(v(0, 1, 8'h00, 0, 8'h00, 1, 0, 1, 0, 2));
    vecs4.push_back(v(0, 1, 8'h00, 0, 8'h00, 1, 0, 1, 0, 3));
    vecs4.push_back(v(0, 1, 8'h00, 0, 8'h00, 1, 0, 1, 1, 4));
    vecs4.push_back(v(0, 0, 8'h00, 1, 8'h77, 1, 0, 0, 1, 4));
    vecs4.push_back(v(0, 1, 8'h77, 0, 8'h00, 1, 0, 1, 1, 4));
    vecs4.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 0));

    // THRESH=1: a single counted match goes straight to HIT
    vecs1.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs1.push_back(v(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0));
    vecs1.push_back(v(0, 1, 8'h00, 0, 8'h00, 1, 0, 1, 1, 1));
    vecs1.push_back(v(0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 1, 1));
    vecs1.push_back(v(0, 0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 0));
    vecs1.push_back(v(0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0));
    vecs1.push_back(v(0, 1, 8'h01, 0, 8'h00, 1, 0, 0, 0, 0));
    vecs1.push_back(v(0, 1, 8'h00, 0, 8'h00, 1, 0, 1, 1, 1));

    @(negedge clock);
    foreach (vecs4[i]) apply(vecs4[i], 1'b0, i);
    foreach (vecs1[i]) apply(vecs1[i], 1'b1, i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
